// File: rtl/next_pc_unit.sv
// next_pc_unit: program-counter sequencer with RUN/PAUSE/HALT control and
// statistics counters. The next pc is chosen from JR, J/JAL, taken branch or
// pc+4, and a syscall either pauses (resume on go) or halts (exit on rst).
// go is a level input: it is only looked at while in PAUSE, and leaving PAUSE
// on the same edge means a held-high go resumes exactly once per pause.
module next_pc_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] HALT_CODE = 32'd10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        Beq,
    input  logic        Bne,
    input  logic        JR,
    input  logic        JMP,
    input  logic        JAL,
    input  logic        SysCall,
    input  logic        equal,
    input  logic [15:0] imm16,
    input  logic [25:0] target26,
    input  logic [31:0] rs_data,
    input  logic [31:0] v0,
    input  logic        go,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
    output logic [1:0]  state,
    output logic [31:0] cycle_count,
    output logic [31:0] jump_count,
    output logic [31:0] branch_count,
    output logic [31:0] taken_count
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_PAUSE = 2'b01,
        ST_HALT  = 2'b10,
        ST_BAD   = 2'b11
    } state_t;

    state_t      state_q;
    logic        is_jump;
    logic        is_branch;
    logic        taken;
    logic [31:0] jr_target;
    logic [31:0] jump_target;
    logic [31:0] branch_target;
    logic [31:0] next_pc;

    assign state    = state_q;
    assign pc_plus4 = pc + 32'd4;

    // Target arithmetic and next-pc priority select for the instruction at pc.
    always_comb begin
        is_jump       = JR | JMP | JAL;
        is_branch     = Beq | Bne;
        taken         = (Beq & equal) | (Bne & ~equal);
        jr_target     = {rs_data[31:2], 2'b00};
        jump_target   = {pc_plus4[31:28], target26, 2'b00};
        branch_target = pc_plus4 + {{14{imm16[15]}}, imm16, 2'b00};
        next_pc       = pc_plus4;
        if (JR) begin
            next_pc = jr_target;
        end else if (JMP | JAL) begin
            next_pc = jump_target;
        end else if (taken) begin
            next_pc = branch_target;
        end
    end

    // Control FSM, pc register and statistics counters; reset wins everywhere.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            pc           <= RESET_PC;
            cycle_count  <= 32'd0;
            jump_count   <= 32'd0;
            branch_count <= 32'd0;
            taken_count  <= 32'd0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    cycle_count <= cycle_count + 32'd1;
                    if (SysCall) begin
                        // pc holds on the syscall; the code in v0 picks the stop kind.
                        state_q <= (v0 == HALT_CODE) ? ST_HALT : ST_PAUSE;
                    end else begin
                        pc <= next_pc;
                        if (is_jump)   jump_count   <= jump_count + 32'd1;
                        if (is_branch) branch_count <= branch_count + 32'd1;
                        if (taken)     taken_count  <= taken_count + 32'd1;
                    end
                end
                ST_PAUSE: begin
                    if (go) begin
                        pc      <= pc_plus4;
                        state_q <= ST_RUN;
                    end
                end
                ST_HALT: begin
                    state_q <= ST_HALT;
                end
                default: begin
                    // Unreachable encoding: recover to RUN without touching pc.
                    state_q <= ST_RUN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb_next_pc_unit: directed scenarios with literal expectations, then random
// stimulus, all checked every cycle against a behavioural model of the unit.
module tb_next_pc_unit;

    logic        clk;
    logic        rst;
    logic        Beq, Bne, JR, JMP, JAL, SysCall, equal, go;
    logic [15:0] imm16;
    logic [25:0] target26;
    logic [31:0] rs_data, v0;
    logic [31:0] pc, pc_plus4;
    logic [1:0]  state;
    logic [31:0] cycle_count, jump_count, branch_count, taken_count;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 0;

    // Behavioural model state: 0 run, 1 pause, 2 halt.
    logic [31:0] m_pc, m_cyc, m_jmp, m_br, m_tk;
    int          m_st;

    next_pc_unit dut (
        .clk(clk), .rst(rst),
        .Beq(Beq), .Bne(Bne), .JR(JR), .JMP(JMP), .JAL(JAL), .SysCall(SysCall),
        .equal(equal), .imm16(imm16), .target26(target26),
        .rs_data(rs_data), .v0(v0), .go(go),
        .pc(pc), .pc_plus4(pc_plus4), .state(state),
        .cycle_count(cycle_count), .jump_count(jump_count),
        .branch_count(branch_count), .taken_count(taken_count)
    );

    // Clock
    initial clk = 0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: what the unit must do on each rising edge, from the rules.
    always @(posedge clk) begin
        logic [31:0] p4, nxt;
        p4 = m_pc + 32'd4;
        if (rst) begin
            m_pc = 32'h0; m_st = 0;
            m_cyc = 0; m_jmp = 0; m_br = 0; m_tk = 0;
        end else if (m_st == 0) begin
            m_cyc = m_cyc + 1;
            if (SysCall) begin
                m_st = (v0 == 32'd10) ? 2 : 1;
            end else begin
                bit tk;
                tk = (Beq && equal) || (Bne && !equal);
                if (JR)              nxt = rs_data & ~32'd3;
                else if (JMP || JAL) nxt = (p4 & 32'hF000_0000) | (32'(target26) << 2);
                else if (tk)         nxt = p4 + 32'($signed(imm16)) * 32'd4;
                else                 nxt = p4;
                m_pc = nxt;
                if (JR || JMP || JAL) m_jmp = m_jmp + 1;
                if (Beq || Bne)       m_br  = m_br + 1;
                if (tk)               m_tk  = m_tk + 1;
            end
        end else if (m_st == 1) begin
            if (go) begin
                m_pc = p4;
                m_st = 0;
            end
        end
    end

    // Compare every output against the model on each falling edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("pc", pc, m_pc);
            check("pc_plus4", pc_plus4, m_pc + 32'd4);
            check("state", {30'd0, state}, m_st);
            check("cycle_count", cycle_count, m_cyc);
            check("jump_count", jump_count, m_jmp);
            check("branch_count", branch_count, m_br);
            check("taken_count", taken_count, m_tk);
        end
    end

    // Driver tasks
    task automatic idle();
        rst = 0; Beq = 0; Bne = 0; JR = 0; JMP = 0; JAL = 0; SysCall = 0;
        equal = 0; go = 0; imm16 = '0; target26 = '0; rs_data = '0; v0 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic jr_to(input logic [31:0] addr);
        idle(); JR = 1; rs_data = addr; tick(); idle();
    endtask

    logic [31:0] save_cyc, save_jmp, save_br, save_tk, save_pc;

    initial begin
        idle();
        rst = 1;
        tick();
        chk_en = 1;
        // Reset state
        check("reset pc", pc, 32'h0);
        check("reset state", {30'd0, state}, 32'd0);
        check("reset cycle_count", cycle_count, 32'd0);
        check("reset taken_count", taken_count, 32'd0);

        // Sequential fetch
        idle();
        tick(); check("seq pc 1", pc, 32'h4);
        tick(); check("seq pc 2", pc, 32'h8);
        tick(); check("seq pc 3", pc, 32'hC);
        check("seq cycle_count", cycle_count, 32'd3);
        tick(); check("seq pc 4", pc, 32'h10);

        // Backward branch taken, then not taken
        Beq = 1; equal = 1; imm16 = 16'hFFFE; tick(); idle();
        check("beq taken pc", pc, 32'h0C);
        check("beq branch_count", branch_count, 32'd1);
        check("beq taken_count", taken_count, 32'd1);
        tick(); check("back to 0x10", pc, 32'h10);
        Beq = 1; equal = 0; imm16 = 16'hFFFE; tick(); idle();
        check("beq not taken pc", pc, 32'h14);
        check("beq nt branch_count", branch_count, 32'd2);
        check("beq nt taken_count", taken_count, 32'd1);

        // Jumps
        jr_to(32'h2000_0040);
        check("jr pc", pc, 32'h2000_0040);
        check("jal link", pc_plus4, 32'h2000_0044);
        JAL = 1; target26 = 26'h0000100; tick(); idle();
        check("jal pc", pc, 32'h2000_0400);
        JR = 1; JMP = 1; rs_data = 32'h103; target26 = 26'h3FFFFFF; tick(); idle();
        check("jr over jmp pc", pc, 32'h100);
        check("jump_count", jump_count, 32'd3);

        // Pause and resume
        jr_to(32'h20);
        SysCall = 1; v0 = 32'd1; Beq = 1; equal = 1; imm16 = 16'h0040; tick(); idle();
        check("pause state", {30'd0, state}, 32'd1);
        check("pause pc", pc, 32'h20);
        save_cyc = cycle_count;
        for (int i = 0; i < 5; i++) begin
            JMP = 1; target26 = 26'h123; tick(); idle();
        end
        check("pause pc held", pc, 32'h20);
        check("pause cycle frozen", cycle_count, save_cyc);
        go = 1; tick(); idle();
        check("resume pc", pc, 32'h24);
        check("resume state", {30'd0, state}, 32'd0);

        // Halt
        SysCall = 1; v0 = 32'd10; tick(); idle();
        check("halt state", {30'd0, state}, 32'd2);
        save_pc = pc; save_cyc = cycle_count; save_jmp = jump_count;
        save_br = branch_count; save_tk = taken_count;
        for (int i = 0; i < 10; i++) begin
            go = i[0]; Beq = 1; equal = 1; JR = i[1]; rs_data = 32'h400; tick();
        end
        idle();
        check("halt pc held", pc, save_pc);
        check("halt cycle held", cycle_count, save_cyc);
        check("halt jump held", jump_count, save_jmp);
        check("halt branch held", branch_count, save_br);
        check("halt taken held", taken_count, save_tk);
        check("halt state held", {30'd0, state}, 32'd2);
        rst = 1; go = 1; tick(); idle();
        check("halt reset pc", pc, 32'h0);
        check("halt reset cycle", cycle_count, 32'd0);
        check("halt reset state", {30'd0, state}, 32'd0);

        // Counter wrap
        tick();
        force dut.cycle_count = 32'hFFFF_FFFF;
        m_cyc = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count;
        tick();
        check("cycle wrap", cycle_count, 32'd0);

        // Reset beats a taken branch
        jr_to(32'h80);
        rst = 1; Beq = 1; equal = 1; imm16 = 16'h0010; tick(); idle();
        check("rst over branch pc", pc, 32'h0);
        check("rst over branch taken", taken_count, 32'd0);

        // Random stimulus
        for (int n = 0; n < 3000; n++) begin
            idle();
            Beq      = ($urandom_range(0, 3) == 0);
            Bne      = ($urandom_range(0, 3) == 0);
            JR       = ($urandom_range(0, 7) == 0);
            JMP      = ($urandom_range(0, 7) == 0);
            JAL      = ($urandom_range(0, 7) == 0);
            SysCall  = ($urandom_range(0, 19) == 0);
            equal    = $urandom_range(0, 1);
            go       = ($urandom_range(0, 2) == 0);
            imm16    = 16'($urandom);
            target26 = 26'($urandom);
            rs_data  = $urandom;
            v0       = ($urandom_range(0, 2) == 0) ? 32'd10 : 32'($urandom_range(0, 12));
            rst      = (m_st == 2) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 199) == 0);
            tick();
        end
        idle();
        tick();
        chk_en = 0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
